// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch redirect controller: FSM states, redirect
// sources ordered by priority, and the source/target pair they travel in.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    PEND,
    HALT
  } fc_state_e;

  // Numeric order is priority order, so a plain compare arbitrates.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JAL  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } redir_src_e;

  typedef struct packed {
    redir_src_e  src;
    logic [31:0] target;
  } redir_t;

  localparam redir_t REDIR_NONE = '{src: SRC_NONE, target: 32'h0};

  // A live request takes over a parked one of equal or lower priority.
  function automatic logic outranks(input redir_src_e req, input redir_src_e parked);
    return (req != SRC_NONE) && (req >= parked);
  endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Fixed-priority select of trap > branch > jal, plus the squash pair the
// winning source implies (jal only squashes IF/ID).
module redirect_arbiter
  import fetch_ctrl_pkg::*;
(
  input  logic        trap_req,
  input  logic [31:0] trap_target,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        jal_req,
  input  logic [31:0] jal_target,
  output redir_t      winner,
  output logic        flush_if_id,
  output logic        flush_id_ex
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner = REDIR_NONE;
    if (trap_req)     winner = '{src: SRC_TRAP, target: trap_target};
    else if (br_req)  winner = '{src: SRC_BR,   target: br_target};
    else if (jal_req) winner = '{src: SRC_JAL,  target: jal_target};
    flush_if_id = (winner.src != SRC_NONE);
    flush_id_ex = (winner.src == SRC_TRAP) || (winner.src == SRC_BR);
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-PC sequencer: applies the winning redirect, parks it while imem is
// busy, holds the PC on stalls, and provides halt and a redirect counter.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trap_req,
  input  logic [31:0]      trap_target,
  input  logic             br_req,
  input  logic [31:0]      br_target,
  input  logic             jal_req,
  input  logic [31:0]      jal_target,
  input  logic             hazard_stall,
  input  logic             imem_ready,
  input  logic             halt_req,
  output logic             pc_enable,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  fc_state_e  state_q, state_d;
  redir_t     pend_q, pend_d, pend_sel;
  redir_t     arb;
  logic       arb_flush_if_id, arb_flush_id_ex;
  logic       live_q;
  logic [CNT_W-1:0] cnt_q;

  redirect_arbiter u_arb (
    .trap_req    (trap_req),
    .trap_target (trap_target),
    .br_req      (br_req),
    .br_target   (br_target),
    .jal_req     (jal_req),
    .jal_target  (jal_target),
    .winner      (arb),
    .flush_if_id (arb_flush_if_id),
    .flush_id_ex (arb_flush_id_ex)
  );

  // live_q is low during reset and the first cycle after release, which
  // pins every output at its reset value for that window.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_sel    = pend_q;
    pc_enable   = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = RESET_VECTOR;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    halted      = 1'b0;
    if (live_q) begin
      unique case (state_q)
        RUN: begin
          if (arb.src != SRC_NONE) begin
            flush_if_id = arb_flush_if_id;
            flush_id_ex = arb_flush_id_ex;
            if (imem_ready) begin
              pc_redirect = 1'b1;
              pc_enable   = 1'b1;
              pc_target   = arb.target;
            end else begin
              pend_d  = arb;
              state_d = PEND;
            end
          end else if (halt_req) begin
            state_d = HALT;
          end else begin
            pc_enable = imem_ready & ~hazard_stall;
          end
        end
        PEND: begin
          if (outranks(arb.src, pend_q.src)) begin
            pend_sel    = arb;
            flush_if_id = arb_flush_if_id;
            flush_id_ex = arb_flush_id_ex;
          end
          pend_d = pend_sel;
          if (imem_ready) begin
            pc_redirect = 1'b1;
            pc_enable   = 1'b1;
            pc_target   = pend_sel.target;
            pend_d      = REDIR_NONE;
            state_d     = RUN;
          end
        end
        HALT: halted = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      // NOTE: the parked target is reset too, so a redirect from before reset can never be replayed.
      pend_q  <= REDIR_NONE;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      live_q  <= 1'b1;
      if (pc_redirect && pc_enable && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign redirect_cnt = cnt_q;

endmodule
